// File: rtl/morph_pkg.sv
// Shared types for the morphology scheduler: FSM states, op vector, op encodings.
package morph_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef logic [3:0] op_vec_t;

  localparam logic OP_EROSION  = 1'b0;
  localparam logic OP_DILATION = 1'b1;

endpackage

// File: rtl/morph_auto_seq.sv
// Demo sequencer: walks all 16 op combinations, holding each for HOLD_FRAMES frames.
module morph_auto_seq
  import morph_pkg::*;
#(
  parameter int HOLD_FRAMES = 60
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    frame_edge,
  input  logic    auto_mode,
  output op_vec_t seq_op
);

  localparam logic [7:0] DWELL_LAST = 8'(HOLD_FRAMES - 1);

  op_vec_t    seq;
  logic [7:0] dwell;
  logic       auto_prev;
  logic       restart;
  op_vec_t    eff_seq;
  logic [7:0] eff_dwell;

  // auto_prev only updates at frame edges, so a rising auto_mode is seen per frame
  assign restart   = auto_mode & ~auto_prev;
  assign eff_seq   = restart ? 4'b0000 : seq;
  assign eff_dwell = restart ? 8'd0 : dwell;
  assign seq_op    = eff_seq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq       <= 4'b0000;
      dwell     <= 8'd0;
      auto_prev <= 1'b0;
    end else if (frame_edge) begin
      auto_prev <= auto_mode;
      if (auto_mode) begin
        if (eff_dwell == DWELL_LAST) begin
          seq   <= eff_seq + 4'd1;
          dwell <= 8'd0;
        end else begin
          seq   <= eff_seq;
          dwell <= eff_dwell + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/morph_sched.sv
// Frame-synchronous scheduler for the img_proc erosion/dilation chain.
// Define MORPH_SCHED_AUTO_EN to build in the auto-sequencing demo mode.
module morph_sched
  import morph_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vert_sync,
  input  logic       video_on,
  input  logic       mask,
  input  logic [3:0] sw_ops,
  input  logic       auto_mode,
  output op_vec_t    stage_op,
  output logic       pipe_flush,
  output logic       mem_en,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES);

  state_t     state;
  state_t     next_state;
  logic       vs_d;
  logic       frame_edge;
  logic [7:0] flush_cnt;
  op_vec_t    next_op;

  assign frame_edge = vs_d & ~vert_sync;

`ifdef MORPH_SCHED_AUTO_EN
  op_vec_t seq_op;

  morph_auto_seq #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_auto_seq (
    .clock      (clock),
    .reset      (reset),
    .frame_edge (frame_edge),
    .auto_mode  (auto_mode),
    .seq_op     (seq_op)
  );

  assign next_op = auto_mode ? seq_op : sw_ops;
`else
  localparam int unused_hold_frames = HOLD_FRAMES;
  logic unused_auto_mode;
  assign unused_auto_mode = auto_mode;
  assign next_op          = sw_ops;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // a frame edge always (re)starts the flush, even mid-flush
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_edge) next_state = FLUSH;
      FLUSH:   if (frame_edge) next_state = FLUSH;
               else if (flush_cnt == 8'd1) next_state = RUN;
      RUN:     if (frame_edge) next_state = FLUSH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == FLUSH);
    mem_en = (state == RUN) & video_on & mask;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_d        <= 1'b1;
      flush_cnt   <= 8'd0;
      stage_op    <= {4{OP_EROSION}};
      frame_count <= 8'd0;
      pipe_flush  <= 1'b0;
    end else begin
      vs_d       <= vert_sync;
      pipe_flush <= (next_state == FLUSH);
      if (frame_edge) begin
        flush_cnt   <= FLUSH_LOAD;
        stage_op    <= next_op;
        frame_count <= frame_count + 8'd1;
      end else if (state == FLUSH && flush_cnt != 8'd0) begin
        flush_cnt <= flush_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_morph_sched.sv
// Scoreboard bench for morph_sched: frame transactions and flush pulse lengths are
// queued by the stimulus and checked by an independent monitor.
module tb_morph_sched;

  logic       clock;
  logic       reset;
  logic       vert_sync;
  logic       video_on;
  logic       mask;
  logic [3:0] sw_ops;
  logic       auto_mode;
  logic [3:0] stage_op;
  logic       pipe_flush;
  logic       mem_en;
  logic       busy;
  logic [7:0] frame_count;

  morph_sched #(
    .FLUSH_CYCLES(4),
    .HOLD_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vert_sync   (vert_sync),
    .video_on    (video_on),
    .mask        (mask),
    .sw_ops      (sw_ops),
    .auto_mode   (auto_mode),
    .stage_op    (stage_op),
    .pipe_flush  (pipe_flush),
    .mem_en      (mem_en),
    .busy        (busy),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] fc;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  int         len_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_fc = 8'd0;
  int         auto_frames = 0;
  logic [7:0] last_fc = 8'd0;
  int         run_len = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp();
    logic [3:0] op;
    op = sw_ops;
`ifdef MORPH_SCHED_AUTO_EN
    if (auto_mode) begin
      op = 4'((auto_frames / 2) % 16);
      auto_frames++;
    end
`endif
    exp_fc = exp_fc + 8'd1;
    exp_q.push_back('{op: op, fc: exp_fc});
  endtask

  task automatic do_frame(input int high);
    vert_sync = 1'b0;
    push_exp();
    len_q.push_back(4);
    tick();
    vert_sync = 1'b1;
    repeat (high) tick();
  endtask

  // monitor: a frame_count change is the DUT presenting a new frame configuration
  always @(negedge clock) begin
    if (reset) begin
      last_fc = 8'd0;
      run_len = 0;
    end else begin
      if (frame_count != last_fc) begin
        if (exp_q.size() == 0) chk("unexpected_frame", 32'(frame_count), 32'(last_fc));
        else begin
          frame_exp_t e;
          e = exp_q.pop_front();
          chk("stage_op", 32'(stage_op), 32'(e.op));
          chk("frame_count", 32'(frame_count), 32'(e.fc));
        end
        last_fc = frame_count;
      end
      if (pipe_flush) run_len++;
      else if (run_len != 0) begin
        if (len_q.size() == 0) chk("unexpected_flush", 32'(run_len), 32'd0);
        else chk("flush_len", 32'(run_len), 32'(len_q.pop_front()));
        run_len = 0;
      end
    end
  end

  initial begin
    reset = 1'b1; vert_sync = 1'b1; video_on = 1'b0; mask = 1'b0;
    sw_ops = 4'b0000; auto_mode = 1'b0;
    repeat (3) tick();
    chk("rst_stage_op", 32'(stage_op), 32'd0);
    chk("rst_pipe_flush", 32'(pipe_flush), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    video_on = 1'b1; mask = 1'b1;
    repeat (6) tick();
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_pipe_flush", 32'(pipe_flush), 32'd0);

    // first frame with explicit flush timing
    vert_sync = 1'b0;
    push_exp();
    len_q.push_back(4);
    tick();
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_pipe", 32'(pipe_flush), 32'd1);
    chk("flush_mem_en", 32'(mem_en), 32'd0);
    vert_sync = 1'b1;
    repeat (3) tick();
    chk("flush_last", 32'(pipe_flush), 32'd1);
    tick();
    chk("run_pipe", 32'(pipe_flush), 32'd0);
    chk("run_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      {video_on, mask} = 2'(i);
      #1;
      chk("run_mem_en", 32'(mem_en), 32'(i == 3));
    end
    video_on = 1'b1; mask = 1'b1;

    // mid-frame switch change must wait for the next frame edge
    tick();
    sw_ops = 4'b1010;
    repeat (5) tick();
    chk("hold_stage_op", 32'(stage_op), 32'd0);
    do_frame(8);

    // back-to-back edges: second edge two clocks into the flush
    sw_ops = 4'b0101;
    vert_sync = 1'b0;
    push_exp();
    tick();
    vert_sync = 1'b1;
    tick();
    sw_ops = 4'b1100;
    vert_sync = 1'b0;
    push_exp();
    len_q.push_back(6);
    tick();
    vert_sync = 1'b1;
    repeat (10) tick();
    chk("b2b_frame_count", 32'(frame_count), 32'd4);

    // 256 frames bring frame_count back to where it started
    for (int i = 0; i < 256; i++) begin
      sw_ops = 4'(i * 7);
      do_frame(6);
    end
    chk("wrap_frame_count", 32'(frame_count), 32'd4);

`ifdef MORPH_SCHED_AUTO_EN
    auto_mode = 1'b1;
    sw_ops = 4'b1001;
    auto_frames = 0;
    for (int i = 0; i < 34; i++) do_frame(6);
    chk("auto_wrap_op", 32'(stage_op), 32'd0);
    auto_mode = 1'b0;
    sw_ops = 4'b0111;
    do_frame(6);
`endif

    // async reset in the middle of a flush
    sw_ops = 4'b0110;
    vert_sync = 1'b0;
    push_exp();
    tick();
    vert_sync = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_pipe_flush", 32'(pipe_flush), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stage_op", 32'(stage_op), 32'd0);
    chk("arst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    len_q.delete();
    exp_fc = 8'd0;
    auto_frames = 0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    sw_ops = 4'b0011;
    do_frame(8);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size() + len_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
